chan_mux_seq: RTL and testbench

Registered, parametrised N-channel, W-bit-wide channel selector with a held select register and an optional automatic scan mode. Generalises the fixed 6-input, 3-bit multiplexer into one block with configurable width and channel count, a latched select, range checking, and a dwell-timed round-robin sequencer. Sits between the switch/data inputs and the display/output logic in the lab datapath.

---
 rtl/chan_mux_seq.sv | 140 ++++++++++++++
 tb/tb_chan_mux_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/chan_mux_seq.sv
// -----------------------------------------------------------------------------
// chan_mux_seq
//   Registered N-channel, W-bit channel selector with a held channel register,
//   range-checked loads and an optional dwell-timed round-robin scanner.
//
//   Optional feature macro: CHAN_MUX_SCAN_EN
//     defined   : i_mode = 1 steps through the channels, spending DWELL cycles on
//                 each one. o_wrap pulses on the step from N-1 back to 0.
//     undefined : i_mode is ignored and o_wrap is tied low. The block is then a
//                 manual registered selector only.
//
// Ports
//   i_clk    rising-edge clock
//   i_reset  synchronous, active-high reset
//   i_d      packed channel data, channel i at i_d[i*W +: W]
//   i_s      requested channel index
//   i_load   capture i_s into the channel register on this edge
//   i_mode   0 = manual hold, 1 = auto scan
//   o_m      registered data of the selected channel
//   o_ch     current channel index
//   o_err    one-cycle pulse when a load requests an index >= N
//   o_wrap   one-cycle pulse when the scan steps from N-1 to 0
// -----------------------------------------------------------------------------
module chan_mux_seq #(
  parameter int W     = 3,
  parameter int N     = 6,
  parameter int DWELL = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N*W-1:0]  i_d,
  input  logic [SW-1:0]   i_s,
  input  logic            i_load,
  input  logic            i_mode,
  output logic [W-1:0]    o_m,
  output logic [SW-1:0]   o_ch,
  output logic            o_err,
  output logic            o_wrap
);

  // The extra bit lets a full-range i_s be compared against N without overflow.
  localparam logic [SW:0]   NUM_CH  = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N-1);

  logic [SW-1:0] r_ch;
  logic [W-1:0]  r_m;
  logic          r_err;

  logic [SW-1:0] w_ch_next;
  logic          w_err_next;
  logic          w_s_ok;
  logic [W-1:0]  w_m_next;

  assign w_s_ok = ({1'b0, i_s} < NUM_CH);

`ifdef CHAN_MUX_SCAN_EN
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL-1);

  logic [CW-1:0] r_cnt;
  logic          r_wrap;
  logic [CW-1:0] w_cnt_next;
  logic          w_wrap_next;

  // Channel selection order: load first (valid or not), then the scan step, then hold.
  // A load always restarts the dwell, so a load landing on the last dwell cycle
  // suppresses that step and its wrap.
  always_comb begin
    w_ch_next   = r_ch;
    w_cnt_next  = '0;
    w_err_next  = 1'b0;
    w_wrap_next = 1'b0;
    if (i_load) begin
      if (w_s_ok) w_ch_next = i_s;
      else        w_err_next = 1'b1;
    end else if (i_mode) begin
      if (r_cnt == CNT_LAST) begin
        w_wrap_next = (r_ch == LAST_CH);
        w_ch_next   = (r_ch == LAST_CH) ? '0 : r_ch + SW'(1);
      end else begin
        w_cnt_next  = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign o_wrap = r_wrap;
`else
  // Scanning is not built. i_mode is kept on the port list so both builds share one interface.
  logic w_mode_unused;
  assign w_mode_unused = i_mode;

  always_comb begin
    w_ch_next  = r_ch;
    w_err_next = 1'b0;
    if (i_load) begin
      if (w_s_ok) w_ch_next = i_s;
      else        w_err_next = 1'b1;
    end
  end

  assign o_wrap = 1'b0;
`endif

  // The output register takes the data of the channel being entered, not the
  // channel being left. o_m and o_ch therefore always describe the same channel.
  always_comb begin
    w_m_next = '0;
    for (int i = 0; i < N; i++) begin
      if (w_ch_next == SW'(i)) w_m_next = i_d[i*W +: W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ch  <= '0;
      r_m   <= '0;
      r_err <= 1'b0;
    end else begin
      r_ch  <= w_ch_next;
      r_m   <= w_m_next;
      r_err <= w_err_next;
    end
  end

  assign o_m   = r_m;
  assign o_ch  = r_ch;
  assign o_err = r_err;

endmodule

// File: tb/tb_chan_mux_seq.sv
module tb_chan_mux_seq;
  localparam int W     = 3;
  localparam int N     = 6;
  localparam int DWELL = 4;
  localparam int SW    = $clog2(N);
`ifdef CHAN_MUX_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset, load, mode;
  logic [SW-1:0]  s;
  logic [N*W-1:0] d;
  logic [W-1:0]   dch [N];
  logic [W-1:0]   m;
  logic [SW-1:0]  ch;
  logic           err, wrap;

  always #5 clk = ~clk;

  always_comb begin
    d = '0;
    for (int i = 0; i < N; i++) d[i*W +: W] = dch[i];
  end

  chan_mux_seq #(.W(W), .N(N), .DWELL(DWELL)) dut (
    .i_clk(clk), .i_reset(reset), .i_d(d), .i_s(s), .i_load(load),
    .i_mode(mode), .o_m(m), .o_ch(ch), .o_err(err), .o_wrap(wrap)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference state, kept as plain integers.
  int e_ch = 0, e_cnt = 0, e_m = 0, e_err = 0, e_wrap = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: reset, load, scan step, hold, in that order.
  task automatic model_edge();
    if (reset) begin
      e_ch = 0; e_cnt = 0; e_m = 0; e_err = 0; e_wrap = 0;
    end else begin
      e_err = 0; e_wrap = 0;
      if (load) begin
        if (int'(s) < N) e_ch = int'(s);
        else             e_err = 1;
        e_cnt = 0;
      end else if (SCAN && mode) begin
        if (e_cnt == DWELL-1) begin
          e_wrap = (e_ch == N-1);
          e_ch   = (e_ch + 1) % N;
          e_cnt  = 0;
        end else e_cnt++;
      end else e_cnt = 0;
      e_m = int'(dch[e_ch]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ch", int'(ch), e_ch);
    check("m", int'(m), e_m);
    check("err", int'(err), e_err);
    check("wrap", int'(wrap), e_wrap);
  endtask

  task automatic idle();
    reset = 0; load = 0;
  endtask

  int ch_hold;

  initial begin
    reset = 1; load = 1; mode = 1; s = 3'd3;
    for (int i = 0; i < N; i++) dch[i] = W'($urandom);
    @(negedge clk);
    step();
    check("rst_ch", int'(ch), 0);
    check("rst_m", int'(m), 0);
    check("rst_err", int'(err), 0);
    check("rst_wrap", int'(wrap), 0);

    // Manual select of channel 4, then live data tracking on it.
    mode = 0; reset = 0;
    for (int i = 0; i < N; i++) dch[i] = W'(i+1);
    load = 1; s = 3'd4; step();
    check("ld_ch4", int'(ch), 4);
    check("ld_m5", int'(m), 5);
    load = 0; dch[4] = 3'd7; step();
    check("track_m7", int'(m), 7);

    // Out-of-range loads leave the channel alone and pulse err.
    load = 1; s = 3'd2; step();
    s = 3'd6; step();
    check("oor6_err", int'(err), 1);
    check("oor6_ch", int'(ch), 2);
    check("oor6_m", int'(m), 3);
    s = 3'd7; step();
    check("oor7_err", int'(err), 1);
    load = 0; step();
    check("err_clr", int'(err), 0);

    if (SCAN) begin
      // Scan from channel 4: step to 5 after 4 edges, wrap to 0 after 8 edges.
      load = 1; s = 3'd4; step();
      load = 0; mode = 1;
      repeat (4) step();
      check("scan_ch5", int'(ch), 5);
      repeat (4) step();
      check("scan_ch0", int'(ch), 0);
      check("scan_wrap", int'(wrap), 1);
      repeat (3) step();
      check("wrap_once", int'(wrap), 0);
      // Load on the last dwell cycle beats the scan step.
      load = 1; s = 3'd1; step();
      check("ldadv_ch", int'(ch), 1);
      check("ldadv_wrap", int'(wrap), 0);
      load = 0;
      repeat (3) step();
      check("ldadv_hold", int'(ch), 1);
      step();
      check("ldadv_next", int'(ch), 2);
    end else begin
      ch_hold = int'(ch);
      mode = 1;
      for (int i = 0; i < 20; i++) begin
        step();
        check("noscan_ch", int'(ch), ch_hold);
        check("noscan_wrap", int'(wrap), 0);
      end
    end

    // Random traffic, with scan runs long enough to wrap.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      load  = ($urandom_range(0, 9) == 0);
      s     = SW'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) dch[$urandom_range(0, N-1)] = W'($urandom);
      step();
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
